// File: rtl/int_ctrl.sv
// int_ctrl: 8-source interrupt controller (PEND/ENABLE/EDGE/INSVC registers, one-level service FSM).
// Build option: define INT_SYNC_EN to pass irq_src through a two-flop synchronizer first.
module int_ctrl #(
  parameter logic [1:0] BANK = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic [7:0] irq_src,
  input  logic [4:0] io_writeaddr,
  input  logic [7:0] io_writedata,
  input  logic       io_write_en,
  input  logic [4:0] io_readaddr,
  output logic [7:0] io_readdata,
  output logic [7:0] io_interrupts,
  input  logic       int_taken,
  input  logic       retint,
  output logic [2:0] int_vector
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] enable_q, enable_d;
  logic [7:0] edge_q, edge_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] rdata_q, rdata_d;
  logic [2:0] vec_q, vec_d;

  logic [7:0] src_s;
  logic [7:0] set_s;
  logic [7:0] clr_s;
  logic [7:0] masked_s;
  logic [7:0] insvc_s;
  logic       wr_hit_s;
  logic       rd_hit_s;
  logic       ret_clr_s;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = v[i] ? 3'(i) : idx;
    end
    return idx;
  endfunction

`ifdef INT_SYNC_EN
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;

  // Synchronizer next-state, frozen while paused
  always_comb begin
    sync1_d = pause ? sync1_q : irq_src;
    sync2_d = pause ? sync2_q : sync1_q;
  end

  // Synchronizer flops
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = irq_src;
`endif

  // Address decode, set/clear vectors and status views
  always_comb begin
    wr_hit_s  = io_write_en && (io_writeaddr[4:3] == BANK);
    rd_hit_s  = (io_readaddr[4:3] == BANK);
    masked_s  = pend_q & enable_q;
    insvc_s   = {(state_q == ACTIVE), 4'b0000, vec_q};
    set_s     = (edge_q & src_s & ~prev_q) | (~edge_q & src_s);
    ret_clr_s = (state_q == ACTIVE) && retint && edge_q[vec_q];
    clr_s     = (wr_hit_s && (io_writeaddr[2:0] == 3'd0)) ? io_writedata : 8'h00;
    clr_s     = clr_s | (ret_clr_s ? (8'h01 << vec_q) : 8'h00);
  end

  // Register file and read-port next-state; set is applied after clear so it wins
  always_comb begin
    pend_d   = pend_q;
    enable_d = enable_q;
    edge_d   = edge_q;
    prev_d   = prev_q;
    rdata_d  = rdata_q;
    if (pause) begin
      pend_d = pend_q;
    end else begin
      pend_d   = (pend_q & ~clr_s) | set_s;
      enable_d = (wr_hit_s && (io_writeaddr[2:0] == 3'd1)) ? io_writedata : enable_q;
      edge_d   = (wr_hit_s && (io_writeaddr[2:0] == 3'd2)) ? io_writedata : edge_q;
      prev_d   = src_s;
      if (rd_hit_s) begin
        case (io_readaddr[2:0])
          3'd0:    rdata_d = pend_q;
          3'd1:    rdata_d = enable_q;
          3'd2:    rdata_d = edge_q;
          3'd3:    rdata_d = insvc_s;
          default: rdata_d = 8'h00;
        endcase
      end else begin
        rdata_d = 8'h00;
      end
    end
  end

  // Service FSM: one interrupt in service at a time, no nesting
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (!pause && int_taken) begin
          state_d = ACTIVE;
          vec_d   = lowest_set(masked_s);
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (!pause && retint) begin
          state_d = IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = IDLE;
        vec_d   = 3'd0;
      end
    endcase
  end

  // State flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pend_q   <= 8'h00;
      enable_q <= 8'h00;
      edge_q   <= 8'h00;
      prev_q   <= 8'h00;
      rdata_q  <= 8'h00;
      vec_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      enable_q <= enable_d;
      edge_q   <= edge_d;
      prev_q   <= prev_d;
      rdata_q  <= rdata_d;
      vec_q    <= vec_d;
    end
  end

  assign io_interrupts = (state_q == IDLE) ? masked_s : 8'h00;
  assign io_readdata   = rdata_q;
  assign int_vector    = vec_q;

endmodule
